// File: rtl/x_ramd_mp.sv
// x_ramd_mp: parametrised distributed RAM with one synchronous write port,
// two independent read ports, an optional registered read stage and a
// sequential clear engine that reloads INIT one address per clock.
//
// Parameters:
//   WIDTH   data bits per word
//   AW      address bits, DEPTH = 2**AW
//   INIT    power-up contents, word k at bits [k*WIDTH +: WIDTH]
//   OUT_REG 0 = combinational read outputs, 1 = outputs registered on CLK/CE
//
// Ports:
//   CLK    clock, rising edge
//   RST    asynchronous active-high reset (control state and output regs only)
//   WE     write enable, ignored while BUSY
//   WADR   write address
//   I      write data
//   RADRA  read address, port A
//   RADRB  read address, port B
//   CE     output register enable (OUT_REG=1 only)
//   CLR    start clear sweep
//   BUSY   clear sweep in progress
//   OA     read data, port A
//   OB     read data, port B
module x_ramd_mp #(
  parameter int                          WIDTH   = 1,
  parameter int                          AW      = 4,
  parameter logic [WIDTH*(2**AW)-1:0]    INIT    = '0,
  parameter bit                          OUT_REG = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [AW-1:0]    WADR,
  input  logic [WIDTH-1:0] I,
  input  logic [AW-1:0]    RADRA,
  input  logic [AW-1:0]    RADRB,
  input  logic             CE,
  input  logic             CLR,
  output logic             BUSY,
  output logic [WIDTH-1:0] OA,
  output logic [WIDTH-1:0] OB
);

  localparam int DEPTH = 2**AW;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   cnt;
  logic            usr_we;
  logic            swp_we;
  logic [WIDTH-1:0] rda;
  logic [WIDTH-1:0] rdb;

  // The array is a flat vector so the power-up contents come straight from
  // INIT; it is never touched by RST.
  logic [WIDTH*DEPTH-1:0] mem = INIT;

  // Clear engine: state register and sweep counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      // Counter wraps to zero on the last sweep address, so it is already
      // cleared for the next sweep without a separate load.
      if (state == SWEEP) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  // Clear engine: next-state logic (CLR is not looked at during a sweep)
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (CLR)  state_nxt = SWEEP;
      SWEEP:   if (&cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear engine: outputs and write arbitration. The sweep owns the write
  // port for its whole duration; user writes are simply dropped.
  always_comb begin
    BUSY   = (state == SWEEP);
    swp_we = (state == SWEEP) && !RST;
    usr_we = WE && (state == IDLE) && !RST;
  end

  // Array write port
  always_ff @(posedge CLK) begin
    if (swp_we) begin
      mem[cnt*WIDTH +: WIDTH] <= INIT[cnt*WIDTH +: WIDTH];
    end else if (usr_we) begin
      mem[WADR*WIDTH +: WIDTH] <= I;
    end
  end

  assign rda = mem[RADRA*WIDTH +: WIDTH];
  assign rdb = mem[RADRB*WIDTH +: WIDTH];

  if (OUT_REG) begin : g_oreg
    logic [WIDTH-1:0] oa_p1;
    logic [WIDTH-1:0] ob_p1;

    // Read stage p1: samples the array before this edge's write lands,
    // which gives read-first behaviour on a shared address.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        oa_p1 <= '0;
        ob_p1 <= '0;
      end else if (CE) begin
        oa_p1 <= rda;
        ob_p1 <= rdb;
      end
    end

    assign OA = oa_p1;
    assign OB = ob_p1;
  end else begin : g_async
    logic ce_unused;
    assign ce_unused = CE;
    assign OA = rda;
    assign OB = rdb;
  end

endmodule

// File: tb/tb_x_ramd_mp.sv
module tb_x_ramd_mp;

  localparam int          WIDTH  = 4;
  localparam int          AW     = 4;
  localparam int          DEPTH  = 16;
  localparam logic [63:0] INIT_V = 64'hFEDCBA9876543210;

  logic       clk = 1'b0;
  logic       rst, we, ce, clr;
  logic [3:0] wadr, i_d, radra, radrb;
  logic       busy_a, busy_r;
  logic [3:0] oa_a, ob_a, oa_r, ob_r;

  x_ramd_mp #(.WIDTH(WIDTH), .AW(AW), .INIT(INIT_V), .OUT_REG(1'b0)) u_async (
    .CLK(clk), .RST(rst), .WE(we), .WADR(wadr), .I(i_d),
    .RADRA(radra), .RADRB(radrb), .CE(ce), .CLR(clr),
    .BUSY(busy_a), .OA(oa_a), .OB(ob_a)
  );

  x_ramd_mp #(.WIDTH(WIDTH), .AW(AW), .INIT(INIT_V), .OUT_REG(1'b1)) u_reg (
    .CLK(clk), .RST(rst), .WE(we), .WADR(wadr), .I(i_d),
    .RADRA(radra), .RADRB(radrb), .CE(ce), .CLR(clr),
    .BUSY(busy_r), .OA(oa_r), .OB(ob_r)
  );

  always #5 clk = ~clk;

  // Reference model: word array, sweep bookkeeping, registered read values
  logic [3:0] m_mem [DEPTH];
  bit         m_busy;
  int         m_pos;
  logic [3:0] m_oa, m_ob;

  typedef struct {
    logic [3:0] oa0, ob0, oa1, ob1;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [3:0] init_word(input int k);
    logic [63:0] v;
    v = INIT_V >> (4 * k);
    return v[3:0];
  endfunction

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model of one rising edge using the inputs currently applied.
  task automatic model_edge();
    if (rst) begin
      m_busy = 1'b0;
      m_pos  = 0;
      m_oa   = 4'h0;
      m_ob   = 4'h0;
    end else begin
      if (ce) begin
        m_oa = m_mem[radra];
        m_ob = m_mem[radrb];
      end
      if (m_busy) begin
        m_mem[m_pos] = init_word(m_pos);
        m_pos++;
        if (m_pos == DEPTH) begin
          m_busy = 1'b0;
          m_pos  = 0;
        end
      end else begin
        if (we) m_mem[wadr] = i_d;
        if (clr) m_busy = 1'b1;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.oa0  = m_mem[radra];
    e.ob0  = m_mem[radrb];
    e.oa1  = m_oa;
    e.ob1  = m_ob;
    e.busy = m_busy;
    q.push_back(e);
  endtask

  task automatic drive(input logic w, input logic [3:0] wa, input logic [3:0] di,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic c, input logic cl);
    we = w; wadr = wa; i_d = di; radra = ra; radrb = rb; ce = c; clr = cl;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    push_exp();
    @(negedge clk);
    #1;
  endtask

  // Edge, then raise RST between edges and expect its effect with no clock.
  task automatic step_then_reset();
    @(posedge clk);
    model_edge();
    #2;
    rst = 1'b1;
    m_busy = 1'b0;
    m_pos  = 0;
    m_oa   = 4'h0;
    m_ob   = 4'h0;
    #1;
    push_exp();
    @(negedge clk);
    #1;
  endtask

  // Monitor: compares every pending expectation at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        check("busy_async", {3'b000, busy_a}, {3'b000, e.busy});
        check("busy_reg",   {3'b000, busy_r}, {3'b000, e.busy});
        check("oa_async", oa_a, e.oa0);
        check("ob_async", ob_a, e.ob0);
        check("oa_reg",   oa_r, e.oa1);
        check("ob_reg",   ob_r, e.ob1);
      end
    end
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) m_mem[k] = init_word(k);
    m_busy = 1'b0; m_pos = 0; m_oa = 4'h0; m_ob = 4'h0;
    rst = 1'b1;
    drive(1'b1, 4'h1, 4'h9, 4'h0, 4'h1, 1'b1, 1'b0);
    // Writes during reset are suppressed; registered outputs stay zero.
    step();
    step();
    rst = 1'b0;

    // Read sweep of INIT contents on both ports
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 4'h0, 4'h0, 4'(k), 4'(15 - k), 1'b1, 1'b0);
      step();
    end

    // Read-during-write to address 3 on both ports
    drive(1'b0, 4'h3, 4'hA, 4'h3, 4'h3, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'h3, 4'hA, 4'h3, 4'h3, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'h3, 4'hA, 4'h3, 4'h3, 1'b1, 1'b0);
    step();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 4'h0, 4'h0, 4'(k), 4'($urandom), 1'b1, 1'b0);
      step();
    end

    // Registered read-first on address 7, then CE=0 hold
    drive(1'b1, 4'h7, 4'h5, 4'h7, 4'h7, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'h7, 4'h5, 4'h7, 4'h7, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'h7, 4'h9, 4'h7, 4'h2, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'h7, 4'h9, 4'h4, 4'h2, 1'b0, 1'b0);
    step();

    // Zero fill, clear sweep with a dropped write, readback
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 4'(k), 4'h0, 4'(k), 4'(k), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 4'h0, 4'h0, 4'h2, 4'h0, 1'b1, 1'b1);
    step();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 4'h2, 4'hF, 4'h2, 4'($urandom), 1'b1, 1'b0);
      step();
    end
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 4'h0, 4'h0, 4'(k), 4'(15 - k), 1'b1, 1'b0);
      step();
    end

    // Reset after five sweep writes
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 4'(k), 4'h0, 4'(k), 4'(k), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 4'h0, 4'h0, 4'h6, 4'h1, 1'b1, 1'b1);
    step();
    drive(1'b0, 4'h0, 4'h0, 4'h6, 4'h1, 1'b1, 1'b0);
    repeat (4) step();
    step_then_reset();
    drive(1'b1, 4'h8, 4'hC, 4'h8, 4'h3, 1'b1, 1'b1);
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 4'h0, 4'h0, 4'(k), 4'($urandom), 1'b1, 1'b0);
      step();
    end

    // CLR held high for 40 cycles, then let the last sweep finish
    for (int k = 0; k < 40; k++) begin
      drive(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b1);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      drive(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b0);
      step();
    end

    // Random traffic with occasional clears and resets
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            ($urandom % 4) != 0, ($urandom % 40) == 0);
      rst = ($urandom % 60) == 0;
      step();
    end
    rst = 1'b0;

    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
